// File: rtl/cmd_phy_sequencer.sv
// SD CMD-line physical-layer sequencer: serializes a 48-bit command, then captures the card response.
// Optional response CRC7 checking is compiled in with `define CMD_RESP_CRC_CHECK_EN.
module cmd_phy_sequencer #(
  parameter int unsigned RESP_BITS = 48,
  parameter int unsigned NCR_MAX   = 64
) (
  input  logic                 sd_clock,
  input  logic                 reset,
  input  logic                 cmd_start,
  input  logic [47:0]          cmd_frame,
  input  logic                 resp_expected,
  input  logic                 ser_complete,
  input  logic                 cmd_in,
  output logic                 ser_enable,
  output logic [7:0]           ser_parallel,
  output logic                 cmd_oe,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [RESP_BITS-1:0] resp,
  output logic                 crc_err
);

  localparam int unsigned BIT_CNT_W = $clog2(RESP_BITS + 1);
  localparam int unsigned NCR_W     = $clog2(NCR_MAX);

  localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = BIT_CNT_W'(RESP_BITS);
  localparam logic [NCR_W-1:0]     NCR_LIMIT    = NCR_W'(NCR_MAX - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SEND      = 3'd1;
  localparam logic [2:0] TX_TAIL   = 3'd2;
  localparam logic [2:0] WAIT_RESP = 3'd3;
  localparam logic [2:0] RECV      = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  logic [2:0]           state_q,    state_d;
  logic [47:0]          frame_q,    frame_d;
  logic                 resp_exp_q, resp_exp_d;
  logic [2:0]           byte_idx_q, byte_idx_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [NCR_W-1:0]     ncr_q,      ncr_d;
  logic [RESP_BITS-1:0] resp_d;
  logic                 timeout_d;
  logic                 done_d;
  logic                 busy_d;
  logic                 ser_enable_d;
  logic                 cmd_oe_d;
  logic [7:0]           ser_parallel_d;
  logic [47:0]          frame_shift;

`ifdef CMD_RESP_CRC_CHECK_EN
  // Start bit is never covered; the long response also skips its reserved header byte.
  localparam logic [BIT_CNT_W-1:0] CRC_FIRST = BIT_CNT_W'((RESP_BITS == 136) ? 8 : 1);
  localparam logic [BIT_CNT_W-1:0] CRC_LAST  = BIT_CNT_W'(RESP_BITS - 9);

  logic [6:0] crc_q, crc_d;
  logic       crc_err_d;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction
`endif

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    resp_exp_d = resp_exp_q;
    byte_idx_d = byte_idx_q;
    bit_cnt_d  = bit_cnt_q;
    ncr_d      = ncr_q;
    resp_d     = resp;
    timeout_d  = timeout;
`ifdef CMD_RESP_CRC_CHECK_EN
    crc_d      = crc_q;
    crc_err_d  = crc_err;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          frame_d    = cmd_frame;
          resp_exp_d = resp_expected;
          resp_d     = '0;
          timeout_d  = 1'b0;
          byte_idx_d = 3'd0;
          state_d    = SEND;
`ifdef CMD_RESP_CRC_CHECK_EN
          crc_d      = 7'd0;
          crc_err_d  = 1'b0;
`endif
        end
      end
      SEND: begin
        if (ser_complete) begin
          if (byte_idx_q == 3'd5) begin
            byte_idx_d = 3'd0;
            state_d    = TX_TAIL;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end
      TX_TAIL: begin
        ncr_d   = '0;
        state_d = resp_exp_q ? WAIT_RESP : DONE;
      end
      WAIT_RESP: begin
        ncr_d = ncr_q + NCR_W'(1);
        // A start bit seen on the final Ncr cycle still counts as a response.
        if (!cmd_in) begin
          resp_d    = {resp[RESP_BITS-2:0], 1'b0};
          bit_cnt_d = BIT_CNT_W'(1);
          state_d   = RECV;
        end else if (ncr_q == NCR_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      RECV: begin
        resp_d    = {resp[RESP_BITS-2:0], cmd_in};
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
`ifdef CMD_RESP_CRC_CHECK_EN
        if (bit_cnt_q >= CRC_FIRST && bit_cnt_q <= CRC_LAST) begin
          crc_d = crc7_step(crc_q, cmd_in);
        end
`endif
        if (bit_cnt_d == BIT_CNT_LAST) begin
          state_d = DONE;
`ifdef CMD_RESP_CRC_CHECK_EN
          crc_err_d = (crc_d != resp_d[7:1]);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    frame_shift    = frame_d << {byte_idx_d, 3'b000};
    done_d         = (state_d == DONE);
    busy_d         = (state_d != IDLE);
    ser_enable_d   = (state_d == SEND);
    cmd_oe_d       = (state_d == SEND) || (state_d == TX_TAIL);
    ser_parallel_d = (state_d == SEND) ? frame_shift[47:40] : 8'd0;
  end

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      frame_q      <= '0;
      resp_exp_q   <= 1'b0;
      byte_idx_q   <= 3'd0;
      bit_cnt_q    <= '0;
      ncr_q        <= '0;
      resp         <= '0;
      timeout      <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      ser_enable   <= 1'b0;
      cmd_oe       <= 1'b0;
      ser_parallel <= 8'd0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      resp_exp_q   <= resp_exp_d;
      byte_idx_q   <= byte_idx_d;
      bit_cnt_q    <= bit_cnt_d;
      ncr_q        <= ncr_d;
      resp         <= resp_d;
      timeout      <= timeout_d;
      done         <= done_d;
      busy         <= busy_d;
      ser_enable   <= ser_enable_d;
      cmd_oe       <= cmd_oe_d;
      ser_parallel <= ser_parallel_d;
    end
  end

`ifdef CMD_RESP_CRC_CHECK_EN
  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      crc_q   <= 7'd0;
      crc_err <= 1'b0;
    end else begin
      crc_q   <= crc_d;
      crc_err <= crc_err_d;
    end
  end
`else
  assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_phy_sequencer.sv
// Self-checking bench for cmd_phy_sequencer: vector table, random transactions against a
// behavioural model, and hand sequences for command injection and mid-transmit reset.
module tb_cmd_phy_sequencer;

  localparam int unsigned RESP_BITS = 48;
  localparam int unsigned NCR_MAX   = 64;
`ifdef CMD_RESP_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic                 sd_clock;
  logic                 reset;
  logic                 cmd_start;
  logic [47:0]          cmd_frame;
  logic                 resp_expected;
  logic                 ser_complete;
  logic                 cmd_in;
  logic                 ser_enable;
  logic [7:0]           ser_parallel;
  logic                 cmd_oe;
  logic                 busy;
  logic                 done;
  logic                 timeout;
  logic [RESP_BITS-1:0] resp;
  logic                 crc_err;

  int checks = 0;
  int errors = 0;

  cmd_phy_sequencer #(.RESP_BITS(RESP_BITS), .NCR_MAX(NCR_MAX)) dut (
    .sd_clock      (sd_clock),
    .reset         (reset),
    .cmd_start     (cmd_start),
    .cmd_frame     (cmd_frame),
    .resp_expected (resp_expected),
    .ser_complete  (ser_complete),
    .cmd_in        (cmd_in),
    .ser_enable    (ser_enable),
    .ser_parallel  (ser_parallel),
    .cmd_oe        (cmd_oe),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .resp          (resp),
    .crc_err       (crc_err)
  );

  initial sd_clock = 1'b0;
  always #5 sd_clock = ~sd_clock;

  // Serializer model: eight shift cycles per byte, ser_complete on the last one.
  logic [2:0] ser_cnt;
  logic [7:0] got_bytes[$];
  assign ser_complete = ser_enable && (ser_cnt == 3'd7);

  always @(posedge sd_clock or posedge reset) begin
    if (reset) ser_cnt <= 3'd0;
    else if (ser_enable) ser_cnt <= ser_cnt + 3'd1;
    else ser_cnt <= 3'd0;
  end

  always @(posedge sd_clock) begin
    if (!reset && ser_complete) got_bytes.push_back(ser_parallel);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // CRC7 (x^7+x^3+1) over received bits 1..RESP_BITS-9, bit 0 being the first received.
  function automatic logic [6:0] crc7_ref(input logic [47:0] r);
    logic [6:0] c;
    logic       b;
    c = 7'd0;
    for (int i = 1; i <= int'(RESP_BITS) - 9; i++) begin
      b = r[RESP_BITS-1-i] ^ c[6];
      c = {c[5:0], 1'b0};
      if (b) c = c ^ 7'h09;
    end
    return c;
  endfunction

  typedef struct {
    logic [47:0] frame;
    bit          rexp;
    int          delay;
    logic [47:0] card;
    bit          inject;
    logic [47:0] exp_resp;
    bit          exp_to;
    bit          exp_crc;
    int          exp_lat;
  } vec_t;

  vec_t tbl[5];

  // One transaction: serializer and card models run alongside, results compared at the end.
  task automatic run_txn(input string tag, input vec_t v);
    int          c;
    int          k;
    int          wait_start;
    int          done_cyc;
    int          done_cnt;
    int          oe_cnt;
    bit          oe_prev;
    logic [47:0] got;
    logic [47:0] d_resp;
    logic        d_to;
    logic        d_crc;
    wait_start = -1;
    done_cyc   = -1;
    done_cnt   = 0;
    oe_cnt     = 0;
    d_resp     = '0;
    d_to       = 1'b0;
    d_crc      = 1'b0;
    got_bytes.delete();
    cmd_frame     = v.frame;
    resp_expected = v.rexp;
    cmd_in        = 1'b1;
    cmd_start     = 1'b1;
    @(posedge sd_clock); #1;
    cmd_start = 1'b0;
    cmd_frame = ~v.frame;
    chk({tag, " start_latency"}, 64'({busy, ser_enable, cmd_oe}), 64'(3'b111));
    chk({tag, " first_byte"}, 64'(ser_parallel), 64'(v.frame[47:40]));
    oe_cnt  = 1;
    oe_prev = 1'b1;
    for (c = 1; c < 600; c++) begin
      @(posedge sd_clock); #1;
      cmd_start = 1'b0;
      if (cmd_oe) oe_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          d_resp   = resp;
          d_to     = timeout;
          d_crc    = crc_err;
        end
      end
      if (!cmd_oe && oe_prev) wait_start = c;
      oe_prev = cmd_oe;
      k = (wait_start >= 0) ? c - wait_start : -1;
      if (v.rexp && k >= 0) begin
        if (k < v.delay) cmd_in = 1'b1;
        else if (k - v.delay < int'(RESP_BITS)) cmd_in = v.card[int'(RESP_BITS) - 1 - (k - v.delay)];
        else cmd_in = 1'b1;
      end
      if (v.inject && c == 12) begin
        cmd_start     = 1'b1;
        resp_expected = ~v.rexp;
      end
      if (v.inject && k == v.delay + 3) cmd_start = 1'b1;
      if (done_cyc >= 0 && c >= done_cyc + 4) break;
    end
    cmd_in = 1'b1;
    if (done_cyc < 0) chk({tag, " done_seen"}, 64'(0), 64'(1));
    got = '0;
    foreach (got_bytes[i]) got = {got[39:0], got_bytes[i]};
    chk({tag, " byte_count"}, 64'(got_bytes.size()), 64'(6));
    chk({tag, " bytes"}, 64'(got), 64'(v.frame));
    chk({tag, " oe_cycles"}, 64'(oe_cnt), 64'(49));
    chk({tag, " done_count"}, 64'(done_cnt), 64'(1));
    chk({tag, " latency"}, 64'(done_cyc - wait_start), 64'(v.exp_lat));
    chk({tag, " resp"}, 64'(d_resp), 64'(v.exp_resp));
    chk({tag, " timeout"}, 64'(d_to), 64'(v.exp_to));
    chk({tag, " crc_err"}, 64'(d_crc), 64'(v.exp_crc));
    chk({tag, " idle_after"}, 64'({busy, ser_enable, cmd_oe, done}), 64'(0));
    chk({tag, " resp_hold"}, 64'(resp), 64'(v.exp_resp));
  endtask

  // Expected results derived from the transaction rules, not from the design's state machine.
  function automatic vec_t model(input logic [47:0] frame, input bit rexp, input int delay,
                                 input logic [47:0] card);
    vec_t v;
    bit   got_resp;
    got_resp  = rexp && (delay < int'(NCR_MAX));
    v.frame   = frame;
    v.rexp    = rexp;
    v.delay   = delay;
    v.card    = card;
    v.inject  = 1'b0;
    v.exp_resp = got_resp ? card : 48'd0;
    v.exp_to   = rexp && !got_resp;
    v.exp_crc  = CRC_EN && got_resp && (crc7_ref(card) != card[7:1]);
    v.exp_lat  = !rexp ? 0 : (got_resp ? delay + int'(RESP_BITS) : int'(NCR_MAX));
    return v;
  endfunction

  initial begin
    logic [47:0] f;
    logic [38:0] payload;
    logic [6:0]  crc;
    vec_t        rv;

    tbl[0] = '{48'h40_0000_0000_95, 1'b0, 0,    48'h0,              1'b0, 48'h0,              1'b0, 1'b0,   0};
    tbl[1] = '{48'h40_0000_0000_95, 1'b1, 5,    48'h08_0000_01AA_13, 1'b0, 48'h08_0000_01AA_13, 1'b0, 1'b0,   53};
    tbl[2] = '{48'h40_0000_0000_95, 1'b1, 1000, 48'h0,              1'b0, 48'h0,              1'b1, 1'b0,   64};
    tbl[3] = '{48'h51_0000_0010_55, 1'b1, 63,   48'h08_0000_01AA_13, 1'b0, 48'h08_0000_01AA_13, 1'b0, 1'b0,   111};
    tbl[4] = '{48'h48_0000_01AA_87, 1'b1, 2,    48'h08_0000_11AA_13, 1'b1, 48'h08_0000_11AA_13, 1'b0, CRC_EN, 50};

    reset         = 1'b1;
    cmd_start     = 1'b0;
    cmd_frame     = '0;
    resp_expected = 1'b0;
    cmd_in        = 1'b1;
    repeat (3) @(posedge sd_clock);
    #1;
    chk("reset_ctrl", 64'({ser_enable, cmd_oe, busy, done, timeout, crc_err}), 64'(0));
    chk("reset_data", 64'({ser_parallel, resp}), 64'(0));
    reset = 1'b0;
    @(posedge sd_clock); #1;

    foreach (tbl[i]) run_txn($sformatf("vec%0d", i), tbl[i]);

    for (int n = 0; n < 10; n++) begin
      f       = {16'($urandom), $urandom};
      payload = {7'($urandom), $urandom};
      crc     = ($urandom_range(0, 1) == 1) ? crc7_ref({1'b0, payload, 8'h01}) : 7'($urandom);
      rv      = model(f, ($urandom_range(0, 3) != 0), $urandom_range(0, NCR_MAX + 8),
                      {1'b0, payload, crc, 1'b1});
      run_txn($sformatf("rand%0d", n), rv);
    end

    // Reset while the fourth byte (byte index 3) is being shifted out.
    got_bytes.delete();
    f             = 48'h7A_1B2C_3D4E_5F;
    cmd_frame     = f;
    resp_expected = 1'b1;
    cmd_start     = 1'b1;
    @(posedge sd_clock); #1;
    cmd_start = 1'b0;
    for (int c = 0; c < 200 && got_bytes.size() < 3; c++) begin
      @(posedge sd_clock); #1;
    end
    repeat (3) @(posedge sd_clock);
    #1;
    chk("abort_byte3", 64'(ser_parallel), 64'(f[23:16]));
    #2 reset = 1'b1;
    #1;
    chk("abort_ctrl", 64'({ser_enable, cmd_oe, busy, done, timeout}), 64'(0));
    chk("abort_data", 64'({ser_parallel, resp}), 64'(0));
    @(posedge sd_clock); #1;
    reset = 1'b0;
    @(posedge sd_clock); #1;
    chk("abort_no_done", 64'({busy, done}), 64'(0));
    run_txn("after_abort", model(48'h4D_0000_0000_E1, 1'b1, 9, 48'h0D_0000_0900_37));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
